// File: rtl/stacker_pkg.sv
// Shared types for the stacker row slider: FSM states, motion direction, colours.
package stacker_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        ADVANCE = 3'd2,
        DRAW    = 3'd3,
        STOPPED = 3'd4
    } state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/slider_step.sv
// Next-x computation for the row slider with a registered travel direction.
// ROW_SLIDER_WRAP_EN: wrap from X_MAX back to 0 instead of bouncing.
module slider_step
    import stacker_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int STEP  = 4,
    parameter int X_MAX = 156
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_i,
    input  logic           advance_i,
    input  logic [X_W-1:0] x_i,
    output logic [X_W-1:0] x_next_o
);

    localparam logic [X_W-1:0] STEP_X = X_W'(STEP);
    localparam logic [X_W-1:0] MAX_X  = X_W'(X_MAX);

    dir_e dir_q, dir_d;

    always_comb begin
        x_next_o = x_i;
        dir_d    = dir_q;
`ifdef ROW_SLIDER_WRAP_EN
        if (x_i >= MAX_X) x_next_o = '0;
        else              x_next_o = x_i + STEP_X;
`else
        if (dir_q == DIR_RIGHT) begin
            if (x_i >= MAX_X) begin
                x_next_o = MAX_X - STEP_X;
                dir_d    = DIR_LEFT;
            end else begin
                x_next_o = x_i + STEP_X;
            end
        end else begin
            if (x_i == '0) begin
                x_next_o = STEP_X;
                dir_d    = DIR_RIGHT;
            end else begin
                x_next_o = x_i - STEP_X;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) dir_q <= DIR_RIGHT;
        else if (advance_i)   dir_q <= dir_d;
    end

endmodule

// File: rtl/row_slider.sv
// Row slider: erase / advance / redraw a block on each movement tick until frozen.
// ROW_SLIDER_WRAP_EN selects wrap-around motion in slider_step.
//
//  state   | meaning
//  IDLE    | waiting for step_en or stop; y tracks level
//  ERASE   | draw_req with BLACK at old position until draw_ack
//  ADVANCE | one cycle, x takes its next value
//  DRAW    | draw_req with colour_in at new position until draw_ack
//  STOPPED | frozen, shows colour_in, waits for new_row
module row_slider
    import stacker_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int LEVEL_W = 6,
    parameter int STEP    = 4,
    parameter int X_MAX   = 156,
    parameter int Y_BASE  = 116,
    parameter int ROW_H   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    input  logic               stop,
    input  logic               new_row,
    input  logic [LEVEL_W-1:0] level,
    input  logic [2:0]         colour_in,
    input  logic               draw_ack,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [2:0]         colour,
    output logic               draw_req,
    output logic               locked,
    output logic               missed_step
);

    state_e         state_q, state_d;
    logic [X_W-1:0] x_q, x_d, x_next;
    logic [Y_W-1:0] y_q, y_d, y_calc;
    logic [2:0]     colour_q, colour_d;
    logic           draw_req_q, draw_req_d;
    logic           locked_q, locked_d;
    logic           missed_q, missed_d;
    logic           advance;
    logic [31:0]    drop_w;

    // Rows stack upward from Y_BASE; anything above the top clamps to 0.
    assign drop_w = 32'(ROW_H) * 32'(level);
    assign y_calc = (drop_w > 32'(Y_BASE)) ? '0 : Y_W'(32'(Y_BASE) - drop_w);

    slider_step #(
        .X_W   (X_W),
        .STEP  (STEP),
        .X_MAX (X_MAX)
    ) u_step (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (new_row),
        .advance_i (advance),
        .x_i       (x_q),
        .x_next_o  (x_next)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        draw_req_d = draw_req_q;
        locked_d   = 1'b0;
        missed_d   = missed_q;
        advance    = 1'b0;

        if (new_row) begin
            state_d    = IDLE;
            x_d        = '0;
            y_d        = y_calc;
            draw_req_d = 1'b0;
        end else begin
            if (step_en && state_q != IDLE) missed_d = 1'b1;
            case (state_q)
                IDLE: begin
                    y_d = y_calc;
                    if (stop) begin
                        state_d    = STOPPED;
                        locked_d   = 1'b1;
                        colour_d   = colour_in;
                        draw_req_d = 1'b0;
                    end else if (step_en) begin
                        state_d    = ERASE;
                        colour_d   = BLACK;
                        draw_req_d = 1'b1;
                    end
                end
                ERASE: begin
                    if (draw_ack) begin
                        state_d    = ADVANCE;
                        draw_req_d = 1'b0;
                    end
                end
                ADVANCE: begin
                    advance    = 1'b1;
                    x_d        = x_next;
                    colour_d   = colour_in;
                    draw_req_d = 1'b1;
                    state_d    = DRAW;
                end
                DRAW: begin
                    if (draw_ack) begin
                        state_d    = IDLE;
                        draw_req_d = 1'b0;
                    end
                end
                STOPPED: begin
                    colour_d   = colour_in;
                    draw_req_d = 1'b0;
                end
                default: begin
                    state_d    = IDLE;
                    draw_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= Y_W'(Y_BASE);
            colour_q   <= BLACK;
            draw_req_q <= 1'b0;
            locked_q   <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            draw_req_q <= draw_req_d;
            locked_q   <= locked_d;
            missed_q   <= missed_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign draw_req    = draw_req_q;
    assign locked      = locked_q;
    assign missed_step = missed_q;

endmodule

// File: tb/tb_row_slider.sv
// Directed bench for row_slider with hand-computed expectations.
// Build with ROW_SLIDER_WRAP_EN defined to exercise the wrap-around variant.
module tb_row_slider;

    logic       clk = 1'b0;
    logic       reset, step_en, stop, new_row, draw_ack;
    logic [5:0] level;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       draw_req, locked, missed_step;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    row_slider dut (
        .clk         (clk),
        .reset       (reset),
        .step_en     (step_en),
        .stop        (stop),
        .new_row     (new_row),
        .level       (level),
        .colour_in   (colour_in),
        .draw_ack    (draw_ack),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .draw_req    (draw_req),
        .locked      (locked),
        .missed_step (missed_step)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Full step with draw_ack held high: IDLE->ERASE->ADVANCE->DRAW->IDLE.
    task automatic step_quiet();
        draw_ack = 1'b1;
        step_en  = 1'b1;
        tick();
        step_en = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b0; step_en = 1'b0; stop = 1'b0; new_row = 1'b0;
        draw_ack = 1'b0; level = 6'd0; colour_in = 3'b101;
        do_reset();

        // Reset state
        check("rst_x", x, 0);
        check("rst_y", y, 116);
        check("rst_colour", colour, 0);
        check("rst_draw_req", draw_req, 0);
        check("rst_locked", locked, 0);
        check("rst_missed", missed_step, 0);

        // First step: erase at 0 in black, then draw at 4 in colour_in
        draw_ack = 1'b1;
        step_en  = 1'b1;
        tick();
        step_en = 1'b0;
        check("erase_req", draw_req, 1);
        check("erase_x", x, 0);
        check("erase_colour", colour, 0);
        tick();
        check("advance_req", draw_req, 0);
        tick();
        check("draw_req", draw_req, 1);
        check("draw_x", x, 4);
        check("draw_colour", colour, 3'b101);
        tick();
        check("idle_req", draw_req, 0);
        check("idle_missed", missed_step, 0);

        // Walk to the right edge (x=4 now, 38 more steps)
        for (int i = 0; i < 38; i++) step_quiet();
        check("edge_x", x, 156);
`ifdef ROW_SLIDER_WRAP_EN
        step_quiet();
        check("wrap_x", x, 0);
        step_quiet();
        check("wrap_then_right", x, 4);
`else
        step_quiet();
        check("bounce_right_x", x, 152);
        step_quiet();
        check("moving_left_x", x, 148);
        for (int i = 0; i < 37; i++) step_quiet();
        check("left_edge_x", x, 0);
        step_quiet();
        check("bounce_left_x", x, 4);
        step_quiet();
        check("moving_right_x", x, 8);
`endif

        // stop + step_en together in IDLE
        do_reset();
        stop = 1'b1;
        step_en = 1'b1;
        tick();
        stop = 1'b0;
        step_en = 1'b0;
        check("stop_locked", locked, 1);
        check("stop_req", draw_req, 0);
        check("stop_colour", colour, 3'b101);
        tick();
        check("stop_locked_drop", locked, 0);
        colour_in = 3'b011;
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        tick();
        check("stopped_req", draw_req, 0);
        check("stopped_x", x, 0);
        check("stopped_colour", colour, 3'b011);
        check("stopped_missed", missed_step, 1);
        check("stopped_locked", locked, 0);

        // new_row recomputes y and leaves STOPPED
        level = 6'd3;
        new_row = 1'b1;
        tick();
        new_row = 1'b0;
        check("row3_y", y, 104);
        check("row3_x", x, 0);
        check("row3_locked", locked, 0);
        level = 6'd40;
        new_row = 1'b1;
        tick();
        new_row = 1'b0;
        check("row40_y", y, 0);
        level = 6'd28;
        tick();
        check("idle_track_y28", y, 4);
        level = 6'd29;
        tick();
        check("idle_track_y29", y, 0);
        step_quiet();
        check("after_row_x", x, 4);

        // Held handshake: draw_req stays, dropped step flags missed_step
        do_reset();
        draw_ack = 1'b0;
        step_en = 1'b1;
        tick();
        check("hold_req0", draw_req, 1);
        tick();
        step_en = 1'b0;
        check("hold_missed", missed_step, 1);
        tick();
        tick();
        check("hold_req1", draw_req, 1);
        check("hold_x", x, 0);
        check("hold_colour", colour, 0);
        check("hold_missed_sticky", missed_step, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_req", draw_req, 0);
        check("rst_mid_missed", missed_step, 0);

        // new_row aborts a pending erase
        draw_ack = 1'b0;
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        new_row = 1'b1;
        level = 6'd1;
        tick();
        new_row = 1'b0;
        check("abort_req", draw_req, 0);
        check("abort_y", y, 112);
        step_quiet();
        check("abort_then_step_x", x, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
